// File: rtl/fp_alu_scheduler_if.sv
// Request, ALU, response and sticky-flag bundle around the shared FP ALU scheduler.
// Signal suffixes (_i/_o) are named from the scheduler's point of view.
interface fp_alu_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 3,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic [NUM_REQ*ADDR_W-1:0] req_op_i;
    logic [NUM_REQ*32-1:0]     req_a_i;
    logic [NUM_REQ*32-1:0]     req_b_i;
    logic [NUM_REQ*32-1:0]     req_c_i;
    logic [NUM_REQ*3-1:0]      req_rmode_i;

    logic [ADDR_W-1:0]         alu_op_o;
    logic [31:0]               alu_a_o;
    logic [31:0]               alu_b_o;
    logic [31:0]               alu_c_o;
    logic [2:0]                alu_rmode_o;
    logic [31:0]               alu_result_i;
    logic                      alu_ovf_i;
    logic                      alu_unf_i;
    logic                      alu_cmp_i;
    logic                      alu_inv_i;

    logic                      resp_valid_o;
    logic                      resp_ready_i;
    logic [ID_W-1:0]           resp_id_o;
    logic [31:0]               resp_result_o;
    logic                      resp_ovf_o;
    logic                      resp_unf_o;
    logic                      resp_cmp_o;
    logic                      resp_inv_o;

    logic                      flag_clr_i;
    logic                      sticky_ovf_o;
    logic                      sticky_unf_o;
    logic                      sticky_inv_o;
    logic                      busy_o;

    modport slave (
        input  req_valid_i, req_op_i, req_a_i, req_b_i, req_c_i, req_rmode_i,
        output req_ready_o,
        output alu_op_o, alu_a_o, alu_b_o, alu_c_o, alu_rmode_o,
        input  alu_result_i, alu_ovf_i, alu_unf_i, alu_cmp_i, alu_inv_i,
        output resp_valid_o, resp_id_o, resp_result_o,
        output resp_ovf_o, resp_unf_o, resp_cmp_o, resp_inv_o,
        input  resp_ready_i, flag_clr_i,
        output sticky_ovf_o, sticky_unf_o, sticky_inv_o, busy_o
    );

    modport master (
        output req_valid_i, req_op_i, req_a_i, req_b_i, req_c_i, req_rmode_i,
        input  req_ready_o,
        input  alu_op_o, alu_a_o, alu_b_o, alu_c_o, alu_rmode_o,
        output alu_result_i, alu_ovf_i, alu_unf_i, alu_cmp_i, alu_inv_i,
        input  resp_valid_o, resp_id_o, resp_result_o,
        input  resp_ovf_o, resp_unf_o, resp_cmp_o, resp_inv_o,
        output resp_ready_i, flag_clr_i,
        input  sticky_ovf_o, sticky_unf_o, sticky_inv_o, busy_o
    );
endinterface

// File: rtl/fp_alu_scheduler.sv
// Round-robin scheduler sharing one combinational FP ALU between NUM_REQ requesters,
// with a fixed settle time, a single tagged response channel and sticky exception flags.
module fp_alu_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 3,
    parameter int LAT_CYC = 2,
    parameter int ID_W    = 2
) (
    input logic               clk_i,
    input logic               rst_i,
    fp_alu_scheduler_if.slave bus
);
    localparam int CNT_W = (LAT_CYC > 1) ? $clog2(LAT_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ADDR_W-1:0] alu_op_q, alu_op_d;
    logic [31:0]       alu_a_q, alu_a_d;
    logic [31:0]       alu_b_q, alu_b_d;
    logic [31:0]       alu_c_q, alu_c_d;
    logic [2:0]        alu_rmode_q, alu_rmode_d;

    logic [31:0]       resp_result_q, resp_result_d;
    logic              resp_ovf_q, resp_ovf_d;
    logic              resp_unf_q, resp_unf_d;
    logic              resp_cmp_q, resp_cmp_d;
    logic              resp_inv_q, resp_inv_d;

    logic              sticky_ovf_q, sticky_ovf_d;
    logic              sticky_unf_q, sticky_unf_d;
    logic              sticky_inv_q, sticky_inv_d;

    logic              grant_any;
    logic [ID_W-1:0]   grant_idx;
    logic              accept;
    logic              capture;

    // Index reached by stepping 'step' places past ptr, wrapping at NUM_REQ.
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] ptr, input int step);
        int sum;
        sum = int'(ptr) + step;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return sum[ID_W-1:0];
    endfunction

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!grant_any && bus.req_valid_i[rr_index(rr_ptr_q, i)]) begin
                grant_any = 1'b1;
                grant_idx = rr_index(rr_ptr_q, i);
            end
        end
    end

    assign accept  = (state_q == S_IDLE) && grant_any;
    assign capture = (state_q == S_EXEC) && (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (grant_any)          state_d = S_EXEC;
            S_EXEC:  if (cnt_q == '0)        state_d = S_RESP;
            S_RESP:  if (bus.resp_ready_i)   state_d = S_IDLE;
            default:                         state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready_o = '0;
        if (state_q == S_IDLE && grant_any) begin
            bus.req_ready_o[grant_idx] = 1'b1;
        end
        bus.busy_o       = (state_q != S_IDLE);
        bus.resp_valid_o = (state_q == S_RESP);
    end

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        id_d          = id_q;
        cnt_d         = cnt_q;
        alu_op_d      = alu_op_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_c_d       = alu_c_q;
        alu_rmode_d   = alu_rmode_q;
        resp_result_d = resp_result_q;
        resp_ovf_d    = resp_ovf_q;
        resp_unf_d    = resp_unf_q;
        resp_cmp_d    = resp_cmp_q;
        resp_inv_d    = resp_inv_q;

        if (accept) begin
            rr_ptr_d    = grant_idx;
            id_d        = grant_idx;
            cnt_d       = CNT_W'(LAT_CYC - 1);
            alu_op_d    = bus.req_op_i[grant_idx*ADDR_W +: ADDR_W];
            alu_a_d     = bus.req_a_i[grant_idx*32 +: 32];
            alu_b_d     = bus.req_b_i[grant_idx*32 +: 32];
            alu_c_d     = bus.req_c_i[grant_idx*32 +: 32];
            alu_rmode_d = bus.req_rmode_i[grant_idx*3 +: 3];
        end

        if (state_q == S_EXEC && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (capture) begin
            resp_result_d = bus.alu_result_i;
            resp_ovf_d    = bus.alu_ovf_i;
            resp_unf_d    = bus.alu_unf_i;
            resp_cmp_d    = bus.alu_cmp_i;
            resp_inv_d    = bus.alu_inv_i;
        end

        // Clear first, then OR in the capture, so a same-cycle capture survives the clear.
        sticky_ovf_d = (bus.flag_clr_i ? 1'b0 : sticky_ovf_q) | (capture & bus.alu_ovf_i);
        sticky_unf_d = (bus.flag_clr_i ? 1'b0 : sticky_unf_q) | (capture & bus.alu_unf_i);
        sticky_inv_d = (bus.flag_clr_i ? 1'b0 : sticky_inv_q) | (capture & bus.alu_inv_i);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= ID_W'(NUM_REQ - 1);
            id_q          <= '0;
            cnt_q         <= '0;
            alu_op_q      <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_c_q       <= '0;
            alu_rmode_q   <= '0;
            resp_result_q <= '0;
            resp_ovf_q    <= 1'b0;
            resp_unf_q    <= 1'b0;
            resp_cmp_q    <= 1'b0;
            resp_inv_q    <= 1'b0;
            sticky_ovf_q  <= 1'b0;
            sticky_unf_q  <= 1'b0;
            sticky_inv_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            id_q          <= id_d;
            cnt_q         <= cnt_d;
            alu_op_q      <= alu_op_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_c_q       <= alu_c_d;
            alu_rmode_q   <= alu_rmode_d;
            resp_result_q <= resp_result_d;
            resp_ovf_q    <= resp_ovf_d;
            resp_unf_q    <= resp_unf_d;
            resp_cmp_q    <= resp_cmp_d;
            resp_inv_q    <= resp_inv_d;
            sticky_ovf_q  <= sticky_ovf_d;
            sticky_unf_q  <= sticky_unf_d;
            sticky_inv_q  <= sticky_inv_d;
        end
    end

    assign bus.alu_op_o      = alu_op_q;
    assign bus.alu_a_o       = alu_a_q;
    assign bus.alu_b_o       = alu_b_q;
    assign bus.alu_c_o       = alu_c_q;
    assign bus.alu_rmode_o   = alu_rmode_q;
    assign bus.resp_id_o     = id_q;
    assign bus.resp_result_o = resp_result_q;
    assign bus.resp_ovf_o    = resp_ovf_q;
    assign bus.resp_unf_o    = resp_unf_q;
    assign bus.resp_cmp_o    = resp_cmp_q;
    assign bus.resp_inv_o    = resp_inv_q;
    assign bus.sticky_ovf_o  = sticky_ovf_q;
    assign bus.sticky_unf_o  = sticky_unf_q;
    assign bus.sticky_inv_o  = sticky_inv_q;
endmodule

// File: tb/tb_fp_alu_scheduler.sv
// Bench for fp_alu_scheduler: an FP ALU stand-in, a table of single-requester vectors,
// directed multi-cycle sequences and a randomized run against a transaction-level model.
module tb_fp_alu_scheduler;
    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 3;
    localparam int LAT_CYC = 2;
    localparam int ID_W    = 2;

    logic clk_i = 1'b0;
    logic rst_i;

    fp_alu_scheduler_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();

    fp_alu_scheduler #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LAT_CYC(LAT_CYC), .ID_W(ID_W)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // Requester side: one operand set per client, packed into the flat buses.
    logic [NUM_REQ-1:0] req_v;
    logic [ADDR_W-1:0]  req_op [NUM_REQ];
    logic [31:0]        req_a  [NUM_REQ];
    logic [31:0]        req_b  [NUM_REQ];
    logic [31:0]        req_c  [NUM_REQ];
    logic [2:0]         req_rm [NUM_REQ];
    logic               force_ovf;

    always_comb begin
        bus.req_valid_i = req_v;
        bus.req_op_i    = '0;
        bus.req_a_i     = '0;
        bus.req_b_i     = '0;
        bus.req_c_i     = '0;
        bus.req_rmode_i = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            bus.req_op_i[k*ADDR_W +: ADDR_W] = req_op[k];
            bus.req_a_i[k*32 +: 32]          = req_a[k];
            bus.req_b_i[k*32 +: 32]          = req_b[k];
            bus.req_c_i[k*32 +: 32]          = req_c[k];
            bus.req_rmode_i[k*3 +: 3]        = req_rm[k];
        end
    end

    // ALU stand-in: op 010 is a truncating single-precision multiply of normal numbers;
    // other ops return a+b+c+rmode. cmp = a<b (unsigned), inv = op 111.
    typedef struct packed {
        logic [31:0] result;
        logic        ovf;
        logic        unf;
        logic        cmp;
        logic        inv;
    } alu_out_t;

    function automatic alu_out_t alu_model(input logic [ADDR_W-1:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] c,
                                           input logic [2:0] rm);
        alu_out_t    o;
        logic [47:0] p;
        logic [22:0] m;
        logic        s;
        int          e;
        o     = '0;
        o.cmp = (a < b);
        o.inv = (op == 3'b111);
        if (op == 3'b010) begin
            s = a[31] ^ b[31];
            p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
            if (p[47]) begin
                m = p[46:24];
                e = int'(a[30:23]) + int'(b[30:23]) - 126;
            end else begin
                m = p[45:23];
                e = int'(a[30:23]) + int'(b[30:23]) - 127;
            end
            if (e >= 255) begin
                o.result = {s, 8'hFF, 23'h0};
                o.ovf    = 1'b1;
            end else if (e <= 0) begin
                o.result = {s, 31'h0};
                o.unf    = 1'b1;
            end else begin
                o.result = {s, e[7:0], m};
            end
        end else begin
            o.result = a + b + c + {29'b0, rm};
        end
        return o;
    endfunction

    alu_out_t alu_now;
    always_comb begin
        alu_now          = alu_model(bus.alu_op_o, bus.alu_a_o, bus.alu_b_o, bus.alu_c_o, bus.alu_rmode_o);
        bus.alu_result_i = alu_now.result;
        bus.alu_ovf_i    = alu_now.ovf | force_ovf;
        bus.alu_unf_i    = alu_now.unf;
        bus.alu_cmp_i    = alu_now.cmp;
        bus.alu_inv_i    = alu_now.inv;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [NUM_REQ-1:0] onehot(input int i);
        return NUM_REQ'(1) << i;
    endfunction

    // Round-robin rule: first pending requester after the last one granted.
    function automatic int rr_next(input logic [NUM_REQ-1:0] pend, input int last);
        for (int s = 1; s <= NUM_REQ; s++) begin
            if (pend[(last + s) % NUM_REQ]) return (last + s) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic post_req(input int k, input logic [ADDR_W-1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] c, input logic [2:0] rm);
        req_op[k] = op;
        req_a[k]  = a;
        req_b[k]  = b;
        req_c[k]  = c;
        req_rm[k] = rm;
        req_v[k]  = 1'b1;
    endtask

    task automatic post_rand(input int k);
        post_req(k, ADDR_W'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                 3'($urandom_range(0, 7)));
    endtask

    task automatic do_reset();
        rst_i            = 1'b1;
        req_v            = '0;
        force_ovf        = 1'b0;
        bus.resp_ready_i = 1'b0;
        bus.flag_clr_i   = 1'b0;
        repeat (2) cyc();
        rst_i = 1'b0;
    endtask

    typedef struct {
        int                idx;
        logic [ADDR_W-1:0] op;
        logic [31:0]       a;
        logic [31:0]       b;
        logic [31:0]       c;
        logic [2:0]        rm;
        logic [31:0]       exp_res;
        logic              exp_ovf;
        logic              exp_unf;
        logic              exp_cmp;
        logic              exp_inv;
    } vec_t;

    // One full transaction for a lone requester, checked cycle by cycle from grant to accept.
    task automatic run_vec(input vec_t v, input string tag);
        req_v = '0;
        post_req(v.idx, v.op, v.a, v.b, v.c, v.rm);
        #1;
        check({tag, "_grant"}, bus.req_ready_o, onehot(v.idx));
        cyc();
        req_v = '0;
        #1;
        check({tag, "_op_t1"}, bus.alu_op_o, v.op);
        check({tag, "_a_t1"}, bus.alu_a_o, v.a);
        check({tag, "_c_t1"}, bus.alu_c_o, v.c);
        check({tag, "_rm_t1"}, bus.alu_rmode_o, v.rm);
        check({tag, "_busy_t1"}, bus.busy_o, 1);
        check({tag, "_valid_t1"}, bus.resp_valid_o, 0);
        cyc();
        check({tag, "_op_t2"}, bus.alu_op_o, v.op);
        check({tag, "_b_t2"}, bus.alu_b_o, v.b);
        check({tag, "_valid_t2"}, bus.resp_valid_o, 0);
        cyc();
        check({tag, "_valid_t3"}, bus.resp_valid_o, 1);
        check({tag, "_id"}, bus.resp_id_o, v.idx);
        check({tag, "_result"}, bus.resp_result_o, v.exp_res);
        check({tag, "_ovf"}, bus.resp_ovf_o, v.exp_ovf);
        check({tag, "_unf"}, bus.resp_unf_o, v.exp_unf);
        check({tag, "_cmp"}, bus.resp_cmp_o, v.exp_cmp);
        check({tag, "_inv"}, bus.resp_inv_o, v.exp_inv);
        bus.resp_ready_i = 1'b1;
        cyc();
        bus.resp_ready_i = 1'b0;
        check({tag, "_idle_after"}, bus.busy_o, 0);
    endtask

    vec_t vecs [6];
    int   rr_order [6] = '{0, 1, 3, 0, 1, 3};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int       n;
        int       last;
        int       w;
        logic     st_ovf, st_unf, st_inv;
        alu_out_t ex;
        vec_t     rv;

        vecs[0] = '{0, 3'b000, 32'h0000_0000, 32'h0000_0000, 32'h0, 3'd0, 32'h0000_0000, 0, 0, 0, 0};
        vecs[1] = '{2, 3'b010, 32'h4040_0000, 32'h4000_0000, 32'h0, 3'd0, 32'h40C0_0000, 0, 0, 0, 0};
        vecs[2] = '{1, 3'b001, 32'h0000_0005, 32'h0000_0007, 32'h1, 3'd3, 32'h0000_0010, 0, 0, 1, 0};
        vecs[3] = '{3, 3'b111, 32'h0000_0010, 32'h0000_0001, 32'h0, 3'd0, 32'h0000_0011, 0, 0, 0, 1};
        vecs[4] = '{1, 3'b010, 32'h7F00_0000, 32'h4000_0000, 32'h0, 3'd0, 32'h7F80_0000, 1, 0, 0, 0};
        vecs[5] = '{0, 3'b010, 32'h0080_0000, 32'h3F00_0000, 32'h0, 3'd0, 32'h0000_0000, 0, 1, 1, 0};
        for (int k = 0; k < NUM_REQ; k++) begin
            req_op[k] = '0; req_a[k] = '0; req_b[k] = '0; req_c[k] = '0; req_rm[k] = '0;
        end

        // Reset state.
        do_reset();
        check("rst_busy", bus.busy_o, 0);
        check("rst_resp_valid", bus.resp_valid_o, 0);
        check("rst_ready", bus.req_ready_o, 0);
        check("rst_alu_op", bus.alu_op_o, 0);
        check("rst_alu_a", bus.alu_a_o, 0);
        check("rst_resp_result", bus.resp_result_o, 0);
        check("rst_resp_id", bus.resp_id_o, 0);
        check("rst_sticky", {bus.sticky_ovf_o, bus.sticky_unf_o, bus.sticky_inv_o}, 0);
        req_v = '1;
        #1;
        check("rst_first_priority", bus.req_ready_o, onehot(0));
        req_v = '0;
        #1;

        // Table of lone-requester transactions, then the sticky flags they leave behind.
        st_ovf = 1'b0; st_unf = 1'b0; st_inv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
            st_ovf |= vecs[i].exp_ovf;
            st_unf |= vecs[i].exp_unf;
            st_inv |= vecs[i].exp_inv;
        end
        check("table_sticky", {bus.sticky_ovf_o, bus.sticky_unf_o, bus.sticky_inv_o},
              {st_ovf, st_unf, st_inv});

        // Requesters 0,1,3 held valid continuously.
        do_reset();
        post_req(0, 3'b001, 32'h1, 32'h0, 32'h0, 3'd0);
        post_req(1, 3'b001, 32'h2, 32'h0, 32'h0, 3'd0);
        post_req(3, 3'b001, 32'h3, 32'h0, 32'h0, 3'd0);
        for (int g = 0; g < 6; g++) begin
            #1;
            check($sformatf("rr_grant%0d", g), bus.req_ready_o, onehot(rr_order[g]));
            n = 0;
            do begin cyc(); n++; end while (!bus.resp_valid_o && n < 10);
            check($sformatf("rr_resp_id%0d", g), bus.resp_id_o, rr_order[g]);
            bus.resp_ready_i = 1'b1;
            cyc();
            bus.resp_ready_i = 1'b0;
        end
        req_v = '0;

        // Response back-pressure for 5 cycles with another request waiting.
        do_reset();
        post_req(1, 3'b001, 32'h1, 32'h2, 32'h3, 3'd1);
        #1;
        check("hold_grant1", bus.req_ready_o, onehot(1));
        cyc();
        req_v[1] = 1'b0;
        post_req(2, 3'b001, 32'hA, 32'h0, 32'h0, 3'd0);
        cyc();
        cyc();
        for (int s = 0; s < 5; s++) begin
            check($sformatf("hold_valid%0d", s), bus.resp_valid_o, 1);
            check($sformatf("hold_result%0d", s), bus.resp_result_o, 32'h7);
            check($sformatf("hold_id%0d", s), bus.resp_id_o, 1);
            check($sformatf("hold_cmp%0d", s), bus.resp_cmp_o, 1);
            check($sformatf("hold_ready%0d", s), bus.req_ready_o, 0);
            cyc();
        end
        bus.resp_ready_i = 1'b1;
        #1;
        check("hold_no_grant_in_handshake", bus.req_ready_o, 0);
        cyc();
        bus.resp_ready_i = 1'b0;
        #1;
        check("hold_next_grant", bus.req_ready_o, onehot(2));
        cyc();
        req_v = '0;
        n = 0;
        do begin cyc(); n++; end while (!bus.resp_valid_o && n < 10);
        check("hold_req2_result", bus.resp_result_o, 32'hA);
        bus.resp_ready_i = 1'b1;
        cyc();
        bus.resp_ready_i = 1'b0;

        // Sticky overflow: forced ovf, then a clear landing on the next capture cycle.
        do_reset();
        force_ovf = 1'b1;
        post_req(0, 3'b000, 32'h1, 32'h1, 32'h0, 3'd0);
        #1;
        cyc();
        req_v = '0;
        cyc();
        cyc();
        check("stk_resp_ovf", bus.resp_ovf_o, 1);
        check("stk_set", bus.sticky_ovf_o, 1);
        bus.resp_ready_i = 1'b1;
        cyc();
        bus.resp_ready_i = 1'b0;
        post_req(0, 3'b000, 32'h2, 32'h2, 32'h0, 3'd0);
        #1;
        cyc();
        req_v = '0;
        cyc();
        bus.flag_clr_i = 1'b1;
        cyc();
        bus.flag_clr_i = 1'b0;
        check("stk_clr_vs_capture", bus.sticky_ovf_o, 1);
        bus.resp_ready_i = 1'b1;
        cyc();
        bus.resp_ready_i = 1'b0;
        force_ovf = 1'b0;
        bus.flag_clr_i = 1'b1;
        cyc();
        bus.flag_clr_i = 1'b0;
        check("stk_clr_idle", bus.sticky_ovf_o, 0);

        // Reset during EXEC drops the op; the retry completes normally.
        post_req(1, 3'b011, 32'h55, 32'h66, 32'h77, 3'd5);
        #1;
        cyc();
        req_v = '0;
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        check("rstx_busy", bus.busy_o, 0);
        check("rstx_resp_valid", bus.resp_valid_o, 0);
        check("rstx_alu_op", bus.alu_op_o, 0);
        check("rstx_alu_abc", bus.alu_a_o | bus.alu_b_o | bus.alu_c_o, 0);
        check("rstx_alu_rm", bus.alu_rmode_o, 0);
        repeat (3) begin
            cyc();
            check("rstx_no_resp", bus.resp_valid_o, 0);
        end
        rv = '{1, 3'b001, 32'h100, 32'h20, 32'h3, 3'd0, 32'h123, 0, 0, 0, 0};
        run_vec(rv, "retry");

        // Reset while a response is waiting.
        post_req(3, 3'b111, 32'h9, 32'h8, 32'h0, 3'd0);
        #1;
        cyc();
        req_v = '0;
        cyc();
        cyc();
        check("rstr_valid_before", bus.resp_valid_o, 1);
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        check("rstr_valid_after", bus.resp_valid_o, 0);
        check("rstr_result", bus.resp_result_o, 0);
        check("rstr_inv", {bus.resp_inv_o, bus.sticky_inv_o}, 0);

        // Randomized traffic against the transaction-level model.
        do_reset();
        last = NUM_REQ - 1;
        st_ovf = 1'b0; st_unf = 1'b0; st_inv = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (req_v == '0) post_rand(int'($urandom_range(0, NUM_REQ - 1)));
            #1;
            w = rr_next(req_v, last);
            check("rnd_grant", bus.req_ready_o, onehot(w));
            ex   = alu_model(req_op[w], req_a[w], req_b[w], req_c[w], req_rm[w]);
            last = w;
            cyc();
            req_v[w] = 1'b0;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!req_v[k] && $urandom_range(0, 2) == 0) post_rand(k);
            end
            n = 0;
            do begin cyc(); n++; end while (!bus.resp_valid_o && n < 10);
            check("rnd_resp_latency", n, LAT_CYC);
            check("rnd_id", bus.resp_id_o, w);
            check("rnd_result", bus.resp_result_o, ex.result);
            check("rnd_flags", {bus.resp_ovf_o, bus.resp_unf_o, bus.resp_cmp_o, bus.resp_inv_o},
                  {ex.ovf, ex.unf, ex.cmp, ex.inv});
            st_ovf |= ex.ovf;
            st_unf |= ex.unf;
            st_inv |= ex.inv;
            check("rnd_sticky", {bus.sticky_ovf_o, bus.sticky_unf_o, bus.sticky_inv_o},
                  {st_ovf, st_unf, st_inv});
            for (int s = int'($urandom_range(0, 3)); s > 0; s--) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.flag_clr_i = 1'b1;
                    st_ovf = 1'b0; st_unf = 1'b0; st_inv = 1'b0;
                end
                cyc();
                bus.flag_clr_i = 1'b0;
                check("rnd_stall_result", bus.resp_result_o, ex.result);
            end
            check("rnd_sticky_after_stall", {bus.sticky_ovf_o, bus.sticky_unf_o, bus.sticky_inv_o},
                  {st_ovf, st_unf, st_inv});
            bus.resp_ready_i = 1'b1;
            #1;
            check("rnd_no_grant_in_handshake", bus.req_ready_o, 0);
            cyc();
            bus.resp_ready_i = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_alu_scheduler.md
Name: fp_alu_scheduler

Overview:
- Shares one combinational FP ALU (op code, A/B/C operands, rounding mode in; result and overflow/underflow/compare/invalid flags out) between NUM_REQ requesters.
- Grants requesters round-robin and registers the winner's operands into the ALU.
- Waits a fixed settle time, captures the result and flags, and returns them on one shared response channel tagged with the requester ID.
- Keeps sticky exception flags for software. Sits between the issue stage of each client and the FP ALU instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 3, ALU op code width.
- LAT_CYC, 2, cycles the ALU inputs are held before capture (≥1).
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester accept; at most one bit high.
- req_op_i  in  NUM_REQ*ADDR_W  op codes; requester k uses slice k.
- req_a_i, req_b_i, req_c_i  in  NUM_REQ*32 each  operands.
- req_rmode_i  in  NUM_REQ*3  rounding modes.
- alu_op_o  out  ADDR_W  to ALU op_code.
- alu_a_o, alu_b_o, alu_c_o  out  32 each  to ALU operands.
- alu_rmode_o  out  3  to ALU rounding mode.
- alu_result_i  in  32  ALU result.
- alu_ovf_i, alu_unf_i, alu_cmp_i, alu_inv_i  in  1 each  ALU flags.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  response consumer ready.
- resp_id_o  out  ID_W  index of the requester that owns the response.
- resp_result_o  out  32  captured result.
- resp_ovf_o, resp_unf_o, resp_cmp_o, resp_inv_o  out  1 each  captured flags.
- flag_clr_i  in  1  clear sticky flags.
- sticky_ovf_o, sticky_unf_o, sticky_inv_o  out  1 each  sticky OR of captured flags.
- busy_o  out  1  high when state ≠ IDLE.

Behaviour:
- Reset:
  - State = IDLE, RR pointer = NUM_REQ-1, so requester 0 has first priority.
  - All alu_*_o = 0, all resp_*_o = 0, resp_valid_o = 0.
  - Sticky flags = 0, busy_o = 0, counter = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready_o is combinationally one-hot to the first valid requester, searching from pointer+1 with wrap-around. All zero if no request.
  - A handshake (valid & ready) in cycle t latches op/a/b/c/rmode into the alu_*_o registers, latches the ID, moves the RR pointer to the granted index, loads the counter with LAT_CYC-1, and goes to EXEC.
- EXEC:
  - alu_*_o hold stable.
  - If counter = 0, capture alu_result_i and the four flags into the resp_* registers and go to RESP. Otherwise decrement the counter.
  - Capture therefore occurs at the end of cycle t+LAT_CYC, and resp_valid_o rises in cycle t+LAT_CYC+1.
- RESP:
  - resp_valid_o = 1 and all resp_* hold stable until resp_ready_i = 1.
  - On the handshake go to IDLE. No new grant is issued in the handshake cycle, so the minimum issue interval is LAT_CYC+2 cycles.
- req_ready_o is 0 in EXEC and RESP. Requesters must hold their inputs stable while valid and not ready.
- alu_*_o keep their last values outside EXEC; they are never zeroed except by reset.
- Sticky flags:
  - Each sticky flag ORs with the corresponding captured flag in the capture cycle.
  - flag_clr_i zeroes them.
  - If clear and capture occur in the same cycle, the sticky value equals the newly captured flag (set wins).
  - cmp has no sticky flag.
- rst_i asserted in any state, including mid-EXEC or RESP with resp_valid_o = 1, returns to the reset values the next cycle. The in-flight operation is dropped and no response is produced.
- Fairness: a continuously requesting client is granted within NUM_REQ grants.

Test Plan:
- Req0 only, op=000, A=0x00000000, B=0x00000000, LAT_CYC=2 -> req_ready_o=0001 at t; resp_valid_o at t+3; resp_id_o=0, result 0x00000000, ovf=unf=0.
- Req2 only, op=010, A=0x40400000 (3.0), B=0x40000000 (2.0) -> alu_op_o=010 at t+1..t+2; response id=2, result 0x40C00000.
- Reqs 0,1,3 held valid continuously after reset -> grant order 0,1,3,0,1,3; no requester granted twice before the others.
- Response held with resp_ready_i=0 for 5 cycles -> resp_* stable and req_ready_o=0 throughout; after accept, next grant comes no earlier than the cycle after the handshake.
- ALU forced alu_ovf_i=1 on one op, then flag_clr_i pulsed on the capture cycle of a second op that has ovf=1 -> sticky_ovf_o stays 1; a clear in a later idle cycle -> 0.
- rst_i during EXEC of a req1 op -> next cycle busy_o=0, resp_valid_o=0, alu_*_o=0; req1's retry gets a normal response.
